// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit.
// Request sizes, FSM states and the default word-index width.
package mips_lsu_pkg;

    localparam int LSU_ADDR_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE
    } state_e;

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for stores.
// Shared by the LOAD and read-modify-write paths.
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{addr, 3'b000} +: 8];
    assign half_v = word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = word;
        st_word = word;
        unique case (size)
            SZ_BYTE: begin
                ld_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
                st_word[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{~is_unsigned & half_v[15]}}, half_v};
                st_word[{addr[1], 4'b0000} +: 16] = wdata;
            end
            default: begin
                ld_data = word;
                st_word = word;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit bridging byte-addressed MIPS requests to a
// word-addressed memory with combinational read and clocked write.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_e              state_q, state_d;
    size_e               size_q;
    logic                uns_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [15:0]         wdata_q;
    logic [31:0]         buf_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]   rd_idx_q, wr_idx_q, idx;
    logic [31:0]         ld_data, st_word;
    logic                accept, req_err;

    assign accept = req_valid & req_ready;
    assign idx    = addr_q[ADDR_W+1:2];

    assign req_err = (req_size == SZ_BAD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                   | (|req_addr[31:ADDR_W+2]);

    lsu_lane_align u_align (
        .word        (mem_read_data),
        .addr        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rdata_d     = ld_data;
            end
            RMW_RD: state_d = STORE;
            STORE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            if (accept) begin
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata[15:0];
                buf_q   <= req_wdata;
            end
            // Merge buffer takes the old word with new lanes spliced in
            if (state_q == RMW_RD) buf_q <= st_word;
            if (mem_read) rd_idx_q <= idx;
            if (mem_write) wr_idx_q <= idx;
        end
    end

    assign req_ready      = rst_n & (state_q == IDLE);
    assign mem_read       = (state_q == LOAD) | (state_q == RMW_RD);
    assign mem_write      = (state_q == STORE);
    assign mem_read_addr  = {{(32-ADDR_W){1'b0}}, mem_read ? idx : rd_idx_q};
    assign mem_write_addr = {{(32-ADDR_W){1'b0}}, mem_write ? idx : wr_idx_q};
    assign mem_write_data = mem_write ? buf_q : 32'h0;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: directed cases plus random traffic checked
// against a byte-array reference memory.
module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [0:255];
    logic [7:0]  ref_b [0:1023];

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int both_hi = 0;

    always #5 clk = ~clk;

    mips_lsu #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem_read ? mem[mem_read_addr[7:0]] : 32'h0;

    always @(posedge clk)
        if (mem_write) mem[mem_write_addr[7:0]] <= mem_write_data;

    always @(negedge clk) begin
        if (mem_write) wr_total++;
        if (mem_read && mem_write) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] v;
        int n;
        n = 1 << sz;
        v = 0;
        for (int k = 0; k < n; k++) v |= 32'(ref_b[a + k]) << (8 * k);
        if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd1024);
    endfunction

    // Caller is at a negedge; returns at the negedge where the response is seen
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int nrd, output int nwr, output int wcyc,
                          output logic [31:0] waddr, output logic [31:0] wdat);
        chk("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; wcyc = 0; rd = 'x; err = 1'bx;
        waddr = 'x; wdat = 'x;
        for (int i = 1; i <= 10; i++) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++; wcyc = i; waddr = mem_write_addr; wdat = mem_write_data;
            end
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; err = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int wcyc,
                       output logic [31:0] waddr, output logic [31:0] wdat);
        logic e_err, g_err;
        logic [31:0] e_rd;
        int e_lat, e_nrd, e_nwr, lat, nrd, nwr;
        e_err = ref_err(a, sz);
        e_rd  = (e_err || we) ? 32'h0 : ref_load(a, sz, uns);
        e_lat = e_err ? 1 : (we && sz != 2'b10) ? 3 : 2;
        e_nrd = (e_err || (we && sz == 2'b10)) ? 0 : 1;
        e_nwr = (!e_err && we) ? 1 : 0;
        if (!e_err && we)
            for (int k = 0; k < (1 << sz); k++) ref_b[a + k] = wd[8*k +: 8];
        do_req(we, sz, uns, a, wd, rd, g_err, lat, nrd, nwr, wcyc, waddr, wdat);
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".err"}, {31'b0, g_err}, {31'b0, e_err});
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".nrd"}, nrd, e_nrd);
        chk({tag, ".nwr"}, nwr, e_nwr);
        if (e_nwr == 1) begin
            chk({tag, ".waddr"}, waddr, {22'b0, a[9:2]});
            chk({tag, ".wdata"}, wdat, ref_word(int'(a[9:2])));
        end
    endtask

    initial begin
        logic [31:0] rd, waddr, wdat, w, a, saved, exp0;
        logic [1:0]  sz;
        logic        we, uns;
        int          wcyc, w0, acc, rsps, nbad;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
        end
        w = 32'h80F0_7F01;
        mem[4] = w;
        for (int k = 0; k < 4; k++) ref_b[16+k] = w[8*k +: 8];

        repeat (2) @(negedge clk);
        chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst.mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst.mem_write_data", mem_write_data, 32'd0);
        rst_n = 1'b1;
        #1 chk("rst.ready_after", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        run("lb11", 0, 2'b00, 0, 32'h11, 0, rd, wcyc, waddr, wdat);
        chk("lb11.lit", rd, 32'h0000_007F);
        run("lb13", 0, 2'b00, 0, 32'h13, 0, rd, wcyc, waddr, wdat);
        chk("lb13.lit", rd, 32'hFFFF_FF80);
        run("lbu13", 0, 2'b00, 1, 32'h13, 0, rd, wcyc, waddr, wdat);
        chk("lbu13.lit", rd, 32'h0000_0080);
        run("lh12", 0, 2'b01, 0, 32'h12, 0, rd, wcyc, waddr, wdat);
        chk("lh12.lit", rd, 32'hFFFF_80F0);
        run("lhu12", 0, 2'b01, 1, 32'h12, 0, rd, wcyc, waddr, wdat);
        chk("lhu12.lit", rd, 32'h0000_80F0);

        run("sb12", 1, 2'b00, 0, 32'h12, 32'h0000_00AB, rd, wcyc, waddr, wdat);
        chk("sb12.wcyc", wcyc, 2);
        chk("sb12.waddr.lit", waddr, 32'd4);
        chk("sb12.wdata.lit", wdat, 32'h80AB_7F01);

        run("sw20", 1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, rd, wcyc, waddr, wdat);
        chk("sw20.waddr.lit", waddr, 32'd8);
        run("lw20", 0, 2'b10, 0, 32'h20, 0, rd, wcyc, waddr, wdat);
        chk("lw20.lit", rd, 32'hDEAD_BEEF);

        run("err_lh11", 0, 2'b01, 0, 32'h11, 0, rd, wcyc, waddr, wdat);
        run("err_lw06", 0, 2'b10, 0, 32'h06, 0, rd, wcyc, waddr, wdat);
        run("err_lw400", 0, 2'b10, 0, 32'h400, 0, rd, wcyc, waddr, wdat);
        run("err_sz3", 0, 2'b11, 0, 32'h10, 0, rd, wcyc, waddr, wdat);
        run("err_sw_oor", 1, 2'b10, 0, 32'h8000_0000, 32'h1234_5678, rd, wcyc, waddr, wdat);

        // Reset pulse in the middle of a sub-word store
        @(negedge clk);
        saved = mem[2];
        w0 = wr_total;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h0000_5A5A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.rmw_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.mem_write", {31'b0, mem_write}, 32'd0);
        chk("rstmid.mem_read", {31'b0, mem_read}, 32'd0);
        chk("rstmid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid.no_write", wr_total - w0, 32'd0);
        chk("rstmid.ready", {31'b0, req_ready}, 32'd1);
        chk("rstmid.rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
        chk("rstmid.word2", mem[2], saved);

        // Streaming loads with req_valid held high
        exp0 = ref_load(32'h0, 2'b10, 1'b0);
        acc = 0; rsps = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) req_valid = 1'b0;
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                rsps++;
                chk("b2b.rdata", rsp_rdata, exp0);
            end
            @(negedge clk);
        end
        chk("b2b.accepts", acc, 5);
        chk("b2b.rsps", rsps, acc);

        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a &= ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 7) == 0) a |= 32'd1 << $urandom_range(10, 31);
            run($sformatf("rnd%0d", n), we, sz, uns, a, $urandom, rd, wcyc, waddr, wdat);
        end

        @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_word(i)) nbad++;
        chk("mem_image", nbad, 0);
        chk("rw_overlap", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
